// File: rtl/debug_pkg.sv
// Shared definitions for the debug run controller: UART command codes,
// FSM state encodings and the fixed PC/register word counts of the dump.
package debug_pkg;

    localparam logic [7:0] CMD_LOAD  = 8'h01;
    localparam logic [7:0] CMD_STEP  = 8'h02;
    localparam logic [7:0] CMD_RUN   = 8'h03;
    localparam logic [7:0] CMD_ABORT = 8'h04;

    localparam int PC_WORDS  = 1;
    localparam int REG_WORDS = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_STEP      = 3'd1,
        ST_RUN       = 3'd2,
        ST_DUMP_LOAD = 3'd3,
        ST_DUMP_SEND = 3'd4,
        ST_DUMP_WAIT = 3'd5
    } dbg_state_t;

endpackage

// File: rtl/dbg_word_serializer.sv
// Splits a 32-bit word into TX_W-bit UART bytes, LSB first, tracking
// which byte of the word is in flight.
module dbg_word_serializer #(
    parameter int TX_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [31:0]     word,
    input  logic            send,
    input  logic            tx_done,
    output logic            tx_start,
    output logic [TX_W-1:0] tx_data,
    output logic            last_byte
);

    logic [31:0] shift_reg;
    logic [1:0]  byte_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg    <= '0;
            byte_cnt_reg <= '0;
        end else if (load) begin
            shift_reg    <= word;
            byte_cnt_reg <= '0;
        end else if (tx_done) begin
            shift_reg    <= shift_reg >> TX_W;
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
        end
    end

    // The shift register only moves on an accepted tx_done, so the byte
    // presented with tx_start stays put until the UART has finished it.
    assign tx_data   = shift_reg[TX_W-1:0];
    assign tx_start  = send;
    assign last_byte = (byte_cnt_reg == 2'd3);

endmodule

// File: rtl/debug_run_ctrl.sv
// Debug run controller: step/run the CPU on UART command, then dump PC,
// registers and data memory over UART. Abort-in-RUN with DEBUG_RUN_ABORT_EN.
module debug_run_ctrl
    import debug_pkg::*;
#(
    parameter int MEM_WORDS = 32,
    parameter int TX_W      = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_rx_done,
    input  logic [7:0]      i_rx_data,
    input  logic            i_load_done,
    input  logic            i_halt,
    input  logic [31:0]     i_pc,
    input  logic [31:0]     i_reg_data,
    input  logic [31:0]     i_mem_data,
    input  logic            i_tx_done,
    output logic            o_cpu_en,
    output logic            o_dbg_rd,
    output logic [4:0]      o_reg_addr,
    output logic [7:0]      o_mem_addr,
    output logic [TX_W-1:0] o_tx_data,
    output logic            o_tx_start,
    output logic            o_busy
);

    localparam int TOTAL_WORDS = PC_WORDS + REG_WORDS + MEM_WORDS;
    localparam int PTR_W       = $clog2(TOTAL_WORDS + 1);
    localparam logic [PTR_W-1:0] REG_BASE = PTR_W'(PC_WORDS);
    localparam logic [PTR_W-1:0] MEM_BASE = PTR_W'(PC_WORDS + REG_WORDS);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(TOTAL_WORDS - 1);

    dbg_state_t       state_reg, state_next;
    logic             loaded_reg;
    logic [PTR_W-1:0] ptr_reg;

    logic        ser_load;
    logic        ser_send;
    logic        ser_tx_done;
    logic        ser_last;
    logic [31:0] dump_word;
    logic        in_regs;
    logic        in_mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            loaded_reg <= 1'b0;
            ptr_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (i_load_done)
                loaded_reg <= 1'b1;
            if (state_reg == ST_IDLE)
                ptr_reg <= '0;
            else if (ser_tx_done && ser_last && ptr_reg != LAST_PTR)
                ptr_reg <= ptr_reg + 1'b1;
        end
    end

    always_comb begin
        state_next  = state_reg;
        o_cpu_en    = 1'b0;
        o_dbg_rd    = 1'b0;
        ser_load    = 1'b0;
        ser_send    = 1'b0;
        ser_tx_done = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // A command arriving alongside i_load_done is dropped.
                if (loaded_reg && i_rx_done && !i_load_done) begin
                    if (i_rx_data == CMD_STEP)
                        state_next = ST_STEP;
                    else if (i_rx_data == CMD_RUN)
                        state_next = ST_RUN;
                end
            end
            ST_STEP: begin
                o_cpu_en   = ~i_halt;
                state_next = ST_DUMP_LOAD;
            end
            ST_RUN: begin
                o_cpu_en = ~i_halt;
                if (i_halt)
                    state_next = ST_DUMP_LOAD;
`ifdef DEBUG_RUN_ABORT_EN
                else if (i_rx_done && i_rx_data == CMD_ABORT)
                    state_next = ST_DUMP_LOAD;
`endif
            end
            ST_DUMP_LOAD: begin
                o_dbg_rd   = 1'b1;
                ser_load   = 1'b1;
                state_next = ST_DUMP_SEND;
            end
            ST_DUMP_SEND: begin
                ser_send   = 1'b1;
                state_next = ST_DUMP_WAIT;
            end
            ST_DUMP_WAIT: begin
                if (i_tx_done) begin
                    ser_tx_done = 1'b1;
                    if (!ser_last)
                        state_next = ST_DUMP_SEND;
                    else if (ptr_reg == LAST_PTR)
                        state_next = ST_IDLE;
                    else
                        state_next = ST_DUMP_LOAD;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Word 0 is the PC, then the register file, then data memory.
    assign in_regs    = (state_reg == ST_DUMP_LOAD) && (ptr_reg >= REG_BASE) && (ptr_reg < MEM_BASE);
    assign in_mem     = (state_reg == ST_DUMP_LOAD) && (ptr_reg >= MEM_BASE);
    assign o_reg_addr = in_regs ? 5'(ptr_reg - REG_BASE) : 5'd0;
    assign o_mem_addr = in_mem  ? 8'(ptr_reg - MEM_BASE) : 8'd0;
    assign dump_word  = (ptr_reg < REG_BASE) ? i_pc : (in_regs ? i_reg_data : i_mem_data);
    assign o_busy     = (state_reg != ST_IDLE);

    dbg_word_serializer #(
        .TX_W(TX_W)
    ) u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (ser_load),
        .word     (dump_word),
        .send     (ser_send),
        .tx_done  (ser_tx_done),
        .tx_start (o_tx_start),
        .tx_data  (o_tx_data),
        .last_byte(ser_last)
    );

endmodule
